// File: rtl/soc_bootrom_arbiter.sv
// ============================================================================
// Module   : soc_bootrom_arbiter
// Purpose  : Round-robin Wishbone arbiter sharing the boot ROM between cores,
//            with a watchdog that turns a missing slave termination into err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_bootrom_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int         c_IW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;
    localparam logic [7:0] c_TMO  = 8'(TIMEOUT);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [c_IW-1:0]        r_gidx;
    logic [c_IW-1:0]        r_last;
    logic [7:0]             r_wdog;
    logic [7:0]             w_wdog_nxt;
    logic [c_IW-1:0]        w_pick;
    logic [c_IW-1:0]        w_cand;
    logic                   w_any_req;
    logic                   w_g_cyc;
    logic                   w_g_stb;
    logic                   w_term;
    logic                   w_timeout;

    assign w_g_cyc = m_cyc_i[r_gidx];
    assign w_term  = s_ack_i | s_err_i | s_rty_i;
    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;

    // Scan downward so the requester closest above r_last is the one kept.
    always_comb begin
        w_pick    = r_last;
        w_cand    = r_last;
        w_any_req = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_cand = c_IW'((int'(r_last) + k) % NUM_MASTERS);
            if (m_cyc_i[w_cand]) begin
                w_pick    = w_cand;
                w_any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= c_IW'(NUM_MASTERS - 1);
            r_wdog  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wdog  <= w_wdog_nxt;
            if (r_state == c_IDLE && w_any_req) begin
                r_grant <= NUM_MASTERS'(1) << w_pick;
                r_gidx  <= w_pick;
            end else if (r_state == c_BUSY && !w_g_cyc) begin
                r_grant <= '0;
                r_last  <= r_gidx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_state_nxt = c_BUSY;
            c_BUSY:  if (!w_g_cyc)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // A real termination in the timeout cycle wins over the watchdog error.
    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        m_ack_o    = '0;
        m_err_o    = '0;
        m_rty_o    = '0;
        w_timeout  = 1'b0;
        w_g_stb    = 1'b0;
        w_wdog_nxt = 8'd0;
        if (r_state == c_BUSY) begin
            w_timeout        = (r_wdog == c_TMO) && !w_term;
            w_g_stb          = m_stb_i[r_gidx] && !w_timeout;
            s_cyc_o          = w_g_cyc;
            s_stb_o          = w_g_stb;
            s_adr_o          = m_adr_i[int'(r_gidx)*AW +: AW];
            s_dat_o          = m_dat_i[int'(r_gidx)*DW +: DW];
            s_sel_o          = m_sel_i[int'(r_gidx)*4 +: 4];
            m_ack_o[r_gidx]  = s_ack_i;
            m_err_o[r_gidx]  = s_err_i | w_timeout;
            m_rty_o[r_gidx]  = s_rty_i;
            if (!w_term && !w_timeout && w_g_stb) begin
                w_wdog_nxt = r_wdog + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_soc_bootrom_arbiter.sv
// ============================================================================
// Module   : tb_soc_bootrom_arbiter
// Purpose  : Self-checking bench for soc_bootrom_arbiter with a boot ROM stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_bootrom_arbiter;

    typedef struct packed {
        logic [3:0]  ack;
        logic [31:0] dat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] m_adr_i;
    logic [127:0] m_dat_i;
    logic [15:0]  m_sel_i;
    logic [3:0]   m_cyc_i;
    logic [3:0]   m_stb_i;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_o;
    logic [3:0]   m_err_o;
    logic [3:0]   m_rty_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic [31:0]  s_dat_i;
    logic         s_ack_i;
    logic         s_err_i = 1'b0;
    logic         s_rty_i = 1'b0;
    logic [3:0]   grant_o;

    logic         rom_en  = 1'b1;
    logic         rom_ack = 1'b0;
    logic [31:0]  rom_dat = 32'd0;

    int           n_checks = 0;
    int           n_errors = 0;
    exp_t         sbq[$];
    int           pend[4];
    logic [3:0]   hold;

    logic [3:0]   obs_grant, obs_ack, obs_err;
    logic         obs_scyc, obs_sstb;
    logic [31:0]  obs_dat;

    always #5 clk = ~clk;

    soc_bootrom_arbiter #(
        .NUM_MASTERS(4), .AW(32), .DW(32), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    function automatic logic [31:0] rom_word(input int idx);
        return 32'hB007_0000 + 32'(idx) * 32'h0000_0101;
    endfunction

    // Boot ROM stub: registered ack on every other strobed cycle, no reset.
    always @(posedge clk) begin
        rom_ack <= rom_en & s_stb_o & ~rom_ack;
        rom_dat <= rom_word(int'(s_adr_o[5:2]));
    end
    assign s_ack_i = rom_ack;
    assign s_dat_i = rom_dat;

    task automatic push(input int i);
        exp_t e;
        e.ack = 4'b0001 << i;
        e.dat = rom_word(i);
        sbq.push_back(e);
    endtask

    task automatic issue(input int i, input int n);
        pend[i]    = n;
        m_cyc_i[i] = 1'b1;
        m_stb_i[i] = 1'b1;
    endtask

    // One clock: sample at the falling edge, score acks, then run the masters.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        obs_grant = grant_o;
        obs_ack   = m_ack_o;
        obs_err   = m_err_o;
        obs_scyc  = s_cyc_o;
        obs_sstb  = s_stb_o;
        obs_dat   = m_dat_o;
        if (obs_ack != 4'b0000) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_ack: got ack=%b, expected none", obs_ack);
            end else begin
                e = sbq.pop_front();
                if (obs_ack !== e.ack || obs_dat !== e.dat) begin
                    n_errors++;
                    $display("FAIL sb_ack: got ack=%b dat=%h, expected ack=%b dat=%h",
                             obs_ack, obs_dat, e.ack, e.dat);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (hold[i]) begin
                hold[i] = 1'b0;
                if (pend[i] > 0) begin
                    m_cyc_i[i] = 1'b1;
                    m_stb_i[i] = 1'b1;
                end
            end else if (m_cyc_i[i] && (obs_ack[i] || obs_err[i])) begin
                m_cyc_i[i] = 1'b0;
                m_stb_i[i] = 1'b0;
                if (pend[i] > 0) pend[i]--;
                hold[i] = 1'b1;
            end
        end
    endtask

    function automatic bit busy();
        return (sbq.size() != 0) || (m_cyc_i != 4'b0000) || (hold != 4'b0000);
    endfunction

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!busy()) break;
            cycle();
        end
        n_checks++;
        if (busy()) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, cyc=%b, expected all done",
                     sbq.size(), m_cyc_i);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        for (int i = 0; i < 4; i++) pend[i] = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (obs_grant !== 4'b0 || obs_scyc !== 1'b0 || obs_sstb !== 1'b0 || obs_ack !== 4'b0) begin
                n_errors++;
                $display("FAIL reset_hold: got grant=%b scyc=%b sstb=%b ack=%b, expected all 0",
                         obs_grant, obs_scyc, obs_sstb, obs_ack);
            end
        end
        for (int i = 0; i < 4; i++) push(i);
        rst = 1'b1;
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_first_grant: got %b, expected 0001", obs_grant);
        end
        drain(60);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g[$];
        logic [3:0] prev;
        int         gap;
        int         seen;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        push(0); push(1); push(2); push(3); push(0);
        issue(0, 2); issue(1, 1); issue(2, 1); issue(3, 1);
        prev = 4'b0; gap = 0; seen = 0;
        for (int k = 0; k < 60 && seen < 5; k++) begin
            cycle();
            if (obs_grant != 4'b0 && obs_grant != prev) begin
                n_checks++;
                if (obs_grant !== exp_g[seen] || (seen > 0 && gap != 1)) begin
                    n_errors++;
                    $display("FAIL rr_order: got grant=%b gap=%0d, expected grant=%b gap=1",
                             obs_grant, gap, exp_g[seen]);
                end
                seen++;
                gap = 0;
            end else if (obs_grant == 4'b0) begin
                gap++;
            end
            prev = obs_grant;
        end
        n_checks++;
        if (seen != 5) begin
            n_errors++;
            $display("FAIL rr_count: got %0d grants, expected 5", seen);
        end
        drain(40);
    endtask

    task automatic test_single_read();
        push(2);
        issue(2, 1);
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0100 || obs_ack !== 4'b0) begin
            n_errors++;
            $display("FAIL read_grant: got grant=%b ack=%b, expected grant=0100 ack=0000",
                     obs_grant, obs_ack);
        end
        cycle();
        n_checks++;
        if (obs_ack !== 4'b0100 || obs_dat !== rom_word(2)) begin
            n_errors++;
            $display("FAIL read_ack: got ack=%b dat=%h, expected ack=0100 dat=%h",
                     obs_ack, obs_dat, rom_word(2));
        end
        drain(10);
    endtask

    task automatic test_timeout();
        rom_en = 1'b0;
        issue(1, 1);
        for (int j = 1; j <= 16; j++) begin
            cycle();
            n_checks++;
            if (j < 16) begin
                if (obs_sstb !== 1'b1 || obs_err !== 4'b0 || obs_grant !== 4'b0010) begin
                    n_errors++;
                    $display("FAIL tmo_wait[%0d]: got sstb=%b err=%b grant=%b, expected 1/0000/0010",
                             j, obs_sstb, obs_err, obs_grant);
                end
            end else if (obs_err !== 4'b0010 || obs_sstb !== 1'b0) begin
                n_errors++;
                $display("FAIL tmo_fire: got err=%b sstb=%b, expected err=0010 sstb=0",
                         obs_err, obs_sstb);
            end
        end
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0 || obs_err !== 4'b0) begin
            n_errors++;
            $display("FAIL tmo_release: got grant=%b err=%b, expected 0000/0000", obs_grant, obs_err);
        end
        rom_en = 1'b1;
        drain(10);
    endtask

    task automatic test_abandoned();
        m_cyc_i[1] = 1'b1;
        m_stb_i[1] = 1'b1;
        pend[1]    = 0;
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0010 || obs_sstb !== 1'b1) begin
            n_errors++;
            $display("FAIL aband_grant: got grant=%b sstb=%b, expected 0010/1", obs_grant, obs_sstb);
        end
        m_cyc_i[1] = 1'b0;
        push(3);
        issue(3, 1);
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0 || obs_ack !== 4'b0) begin
            n_errors++;
            $display("FAIL aband_late_ack: got grant=%b ack=%b, expected 0000/0000", obs_grant, obs_ack);
        end
        m_stb_i[1] = 1'b0;
        cycle();
        n_checks++;
        if (obs_grant !== 4'b1000) begin
            n_errors++;
            $display("FAIL aband_next: got grant=%b, expected 1000", obs_grant);
        end
        drain(20);
    endtask

    task automatic test_mid_reset();
        issue(2, 1);
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0100 || obs_sstb !== 1'b1) begin
            n_errors++;
            $display("FAIL mrst_busy: got grant=%b sstb=%b, expected 0100/1", obs_grant, obs_sstb);
        end
        rst = 1'b0;
        push(0);
        push(2);
        issue(0, 1);
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0 || obs_scyc !== 1'b0 || obs_sstb !== 1'b0 ||
            obs_ack !== 4'b0 || obs_err !== 4'b0) begin
            n_errors++;
            $display("FAIL mrst_idle: got grant=%b scyc=%b sstb=%b ack=%b err=%b, expected all 0",
                     obs_grant, obs_scyc, obs_sstb, obs_ack, obs_err);
        end
        rst = 1'b1;
        cycle();
        n_checks++;
        if (obs_grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL mrst_first: got grant=%b, expected 0001", obs_grant);
        end
        drain(30);
    endtask

    initial begin
        rst     = 1'b0;
        m_cyc_i = 4'b0;
        m_stb_i = 4'b0;
        m_sel_i = 16'hFFFF;
        m_dat_i = '0;
        hold    = 4'b0;
        for (int i = 0; i < 4; i++) begin
            m_adr_i[i*32 +: 32] = 32'(i * 4);
            pend[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_single_read();
        test_timeout();
        test_abandoned();
        test_mid_reset();
        n_checks++;
        if (sbq.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d entries, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000, expected earlier finish");
        $fatal(1, "simulation time bound expired");
    end

endmodule

`default_nettype wire
